// File: rtl/genius_pkg.sv
`default_nettype none
// ============================================================================
// Module   : genius_pkg
// Purpose  : Shared types and constants for the Genius sequence engine:
//            FSM state encoding, LFSR default seed and Galois tap mask, and
//            the one-hot symbol decoder.
// Revision : 1.0  initial release
// ============================================================================
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GEN       = 3'd1,
        ST_PLAY_ON   = 3'd2,
        ST_PLAY_OFF  = 3'd3,
        ST_WAIT_USER = 3'd4,
        ST_WIN       = 3'd5,
        ST_LOSE      = 3'd6
    } state_t;

    // Value loaded at reset and whenever a zero seed is requested; an all-zero
    // Galois LFSR would lock up.
    localparam logic [15:0] C_LFSR_SEED = 16'hACE1;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] C_LFSR_TAPS = 16'hB400;

    // Widest button bank supported; callers size-cast down to N_BTN.
    localparam int C_MAX_BTN = 16;

    function automatic logic [C_MAX_BTN-1:0] onehot(input logic [3:0] sym);
        onehot = {{(C_MAX_BTN-1){1'b0}}, 1'b1} << sym;
    endfunction

endpackage
`default_nettype wire

// File: rtl/genius_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : genius_lfsr16
// Purpose  : 16-bit Galois LFSR used as the sequence symbol source.
// Ports    : clk      system clock
//            i_rst_n  synchronous active-low reset (state <- default seed)
//            i_load   load i_seed (zero seed maps to the default seed)
//            i_seed   seed value
//            i_step   advance one step
//            o_sym    low OUT_W bits of the *next* state, i.e. the symbol
//                     produced by the step taken when i_step is high
// Revision : 1.0  initial release
// ============================================================================
module genius_lfsr16 #(
    parameter int OUT_W = 2
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [15:0]      i_seed,
    input  logic             i_step,
    output logic [OUT_W-1:0] o_sym
);
    import genius_pkg::*;

    logic [15:0] r_state;
    logic [15:0] w_next;

    always_comb begin
        w_next = {1'b0, r_state[15:1]};
        if (r_state[0]) begin
            w_next = w_next ^ C_LFSR_TAPS;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_state <= C_LFSR_SEED;
        end else if (i_load) begin
            r_state <= (i_seed == 16'h0000) ? C_LFSR_SEED : i_seed;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_sym = w_next[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/genius_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : genius_seq_core
// Purpose  : Genius memory-game sequence engine. Grows an LFSR-generated
//            symbol sequence by one entry per round, plays it on the LEDs,
//            checks user presses, and tracks timeout, round and points.
// Ports    : CLOCK_50       system clock
//            reset          synchronous active-low reset
//            start          one-cycle game start pulse
//            tick           playback-rate enable
//            btn            debounced one-hot press pulses
//            target_len     rounds to win (latched on start, clamped 1..MAX_LEN)
//            timeout_ticks  ticks allowed per press (latched on start, 0 -> 1)
//            seed           LFSR seed (latched on start, 0 -> default)
//            leds           playback drive, one-hot or zero
//            round          current sequence length
//            points         accumulated, saturating score
//            busy           game in progress
//            user_turn      input window open
//            match          one-cycle pulse per correct press
//            win / lose     held result flags
// Options  : GENIUS_RETRY_EN - first failure in a round replays the sequence
//            instead of ending the game.
// Revision : 1.0  initial release
// ============================================================================
module genius_seq_core #(
    parameter int N_BTN   = 4,
    parameter int MAX_LEN = 16,
    parameter int SYM_W   = $clog2(N_BTN),
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int TO_W    = 4,
    parameter int PTS_W   = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             start,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn,
    input  logic [LEN_W-1:0] target_len,
    input  logic [TO_W-1:0]  timeout_ticks,
    input  logic [15:0]      seed,
    output logic [N_BTN-1:0] leds,
    output logic [LEN_W-1:0] round,
    output logic [PTS_W-1:0] points,
    output logic             busy,
    output logic             user_turn,
    output logic             match,
    output logic             win,
    output logic             lose
);
    import genius_pkg::*;

    localparam int               IDX_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  C_TO_ONE  = TO_W'(1);

    state_t             r_state,   w_state_nxt;
    logic [LEN_W-1:0]   r_round,   w_round_nxt;
    logic [LEN_W-1:0]   r_index,   w_index_nxt;
    logic [LEN_W-1:0]   r_target,  w_target_nxt;
    logic [TO_W-1:0]    r_timer,   w_timer_nxt;
    logic [TO_W-1:0]    r_timeout, w_timeout_nxt;
    logic [PTS_W-1:0]   r_points,  w_points_nxt;
    logic               r_win,     w_win_nxt;
    logic               r_lose,    w_lose_nxt;
    logic               r_match,   w_match_nxt;
    logic [N_BTN-1:0]   r_leds;
    logic               r_busy;
    logic               r_user_turn;

    logic               w_lfsr_load;
    logic               w_lfsr_step;
    logic               w_seq_we;
    logic               w_fail;
    logic [SYM_W-1:0]   w_gen_sym;
    logic [SYM_W-1:0]   w_led_sym;
    logic [LEN_W-1:0]   w_last;
    logic               w_btn_ok;
    logic [PTS_W:0]     w_sum;
    logic [TO_W-1:0]    w_timer_inc;

    logic [SYM_W-1:0]   r_seq [MAX_LEN];

`ifdef GENIUS_RETRY_EN
    logic               r_retry, w_retry_nxt;
`endif

    genius_lfsr16 #(
        .OUT_W   (SYM_W)
    ) u_lfsr (
        .clk     (CLOCK_50),
        .i_rst_n (reset),
        .i_load  (w_lfsr_load),
        .i_seed  (seed),
        .i_step  (w_lfsr_step),
        .o_sym   (w_gen_sym)
    );

    assign w_last      = r_round - C_LEN_ONE;
    assign w_timer_inc = r_timer + C_TO_ONE;
    assign w_sum       = {1'b0, r_points} + (PTS_W+1)'(r_round);
    // Full-width compare: any extra or wrong bit fails, so this also enforces
    // "exactly one button".
    assign w_btn_ok    = (16'(btn) == onehot(4'(r_seq[r_index[IDX_W-1:0]])));

    // In GEN the entry being written may be the one about to be displayed
    // (round 1), so forward the fresh symbol instead of the stale array entry.
    assign w_led_sym = (w_seq_we && (w_index_nxt == w_last)) ? w_gen_sym
                                                             : r_seq[w_index_nxt[IDX_W-1:0]];

    always_comb begin
        w_state_nxt   = r_state;
        w_round_nxt   = r_round;
        w_index_nxt   = r_index;
        w_target_nxt  = r_target;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = r_timeout;
        w_points_nxt  = r_points;
        w_win_nxt     = r_win;
        w_lose_nxt    = r_lose;
        w_match_nxt   = 1'b0;
        w_lfsr_load   = 1'b0;
        w_lfsr_step   = 1'b0;
        w_seq_we      = 1'b0;
        w_fail        = 1'b0;
`ifdef GENIUS_RETRY_EN
        w_retry_nxt   = r_retry;
`endif

        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    if (target_len == '0) begin
                        w_target_nxt = C_LEN_ONE;
                    end else if (target_len > C_LEN_MAX) begin
                        w_target_nxt = C_LEN_MAX;
                    end else begin
                        w_target_nxt = target_len;
                    end
                    w_timeout_nxt = (timeout_ticks == '0) ? C_TO_ONE : timeout_ticks;
                    w_lfsr_load   = 1'b1;
                    w_round_nxt   = C_LEN_ONE;
                    w_points_nxt  = '0;
                    w_index_nxt   = '0;
                    w_timer_nxt   = '0;
                    w_win_nxt     = 1'b0;
                    w_lose_nxt    = 1'b0;
                    w_state_nxt   = ST_GEN;
                end
            end

            ST_GEN: begin
                w_lfsr_step = 1'b1;
                w_seq_we    = 1'b1;
                w_index_nxt = '0;
`ifdef GENIUS_RETRY_EN
                w_retry_nxt = 1'b0;
`endif
                w_state_nxt = ST_PLAY_ON;
            end

            ST_PLAY_ON: begin
                if (tick) begin
                    w_state_nxt = ST_PLAY_OFF;
                end
            end

            ST_PLAY_OFF: begin
                if (tick) begin
                    if (r_index == w_last) begin
                        w_index_nxt = '0;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_WAIT_USER;
                    end else begin
                        w_index_nxt = r_index + C_LEN_ONE;
                        w_state_nxt = ST_PLAY_ON;
                    end
                end
            end

            ST_WAIT_USER: begin
                // A press wins over a coincident tick.
                if (btn != '0) begin
                    if (w_btn_ok) begin
                        w_match_nxt = 1'b1;
                        w_timer_nxt = '0;
                        if (r_index == w_last) begin
                            w_points_nxt = w_sum[PTS_W] ? {PTS_W{1'b1}} : w_sum[PTS_W-1:0];
                            if (r_round == r_target) begin
                                w_win_nxt   = 1'b1;
                                w_state_nxt = ST_WIN;
                            end else begin
                                w_round_nxt = r_round + C_LEN_ONE;
                                w_state_nxt = ST_GEN;
                            end
                        end else begin
                            w_index_nxt = r_index + C_LEN_ONE;
                        end
                    end else begin
                        w_fail = 1'b1;
                    end
                end else if (tick) begin
                    if (w_timer_inc == r_timeout) begin
                        w_fail = 1'b1;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_fail) begin
`ifdef GENIUS_RETRY_EN
            if (!r_retry) begin
                w_retry_nxt = 1'b1;
                w_index_nxt = '0;
                w_timer_nxt = '0;
                w_state_nxt = ST_PLAY_ON;
            end else begin
                w_lose_nxt  = 1'b1;
                w_state_nxt = ST_LOSE;
            end
`else
            w_lose_nxt  = 1'b1;
            w_state_nxt = ST_LOSE;
`endif
        end
    end

    // Outputs are registered from next-state values so they line up with the
    // state they describe rather than lagging it by a cycle.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_index     <= '0;
            r_target    <= '0;
            r_timer     <= '0;
            r_timeout   <= '0;
            r_points    <= '0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_match     <= 1'b0;
            r_leds      <= '0;
            r_busy      <= 1'b0;
            r_user_turn <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_index     <= w_index_nxt;
            r_target    <= w_target_nxt;
            r_timer     <= w_timer_nxt;
            r_timeout   <= w_timeout_nxt;
            r_points    <= w_points_nxt;
            r_win       <= w_win_nxt;
            r_lose      <= w_lose_nxt;
            r_match     <= w_match_nxt;
            r_leds      <= (w_state_nxt == ST_PLAY_ON) ? N_BTN'(onehot(4'(w_led_sym))) : '0;
            r_busy      <= (w_state_nxt == ST_GEN)     || (w_state_nxt == ST_PLAY_ON) ||
                           (w_state_nxt == ST_PLAY_OFF) || (w_state_nxt == ST_WAIT_USER);
            r_user_turn <= (w_state_nxt == ST_WAIT_USER);
        end
    end

`ifdef GENIUS_RETRY_EN
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            r_retry <= 1'b0;
        end else begin
            r_retry <= w_retry_nxt;
        end
    end
`endif

    // Sequence storage keeps its contents across reset; only new rounds
    // overwrite entries.
    always_ff @(posedge CLOCK_50) begin
        if (reset && w_seq_we) begin
            r_seq[w_last[IDX_W-1:0]] <= w_gen_sym;
        end
    end

    assign leds      = r_leds;
    assign round     = r_round;
    assign points    = r_points;
    assign busy      = r_busy;
    assign user_turn = r_user_turn;
    assign match     = r_match;
    assign win       = r_win;
    assign lose      = r_lose;

endmodule
`default_nettype wire

// File: tb/tb_genius_seq_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_genius_seq_core
// Purpose  : Self-checking bench for genius_seq_core with a reference LFSR
//            and sequence model; press outcomes go through a scoreboard queue.
//            Honours GENIUS_RETRY_EN when the design is built with it.
// Revision : 1.0  initial release
// ============================================================================
module tb_genius_seq_core;

    localparam int MAX_LEN = 16;
`ifdef GENIUS_RETRY_EN
    localparam int N_ATT = 2;
`else
    localparam int N_ATT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, start, tick;
    logic [3:0]  btn;
    logic [4:0]  target_len;
    logic [3:0]  timeout_ticks;
    logic [15:0] seed;
    logic [3:0]  leds;
    logic [4:0]  round;
    logic [7:0]  points;
    logic        busy, user_turn, match, win, lose;

    always #5 clk = ~clk;

    genius_seq_core dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .start         (start),
        .tick          (tick),
        .btn           (btn),
        .target_len    (target_len),
        .timeout_ticks (timeout_ticks),
        .seed          (seed),
        .leds          (leds),
        .round         (round),
        .points        (points),
        .busy          (busy),
        .user_turn     (user_turn),
        .match         (match),
        .win           (win),
        .lose          (lose)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic m;
        logic l;
    } exp_t;
    exp_t sb[$];

    logic [15:0] lfsr_m;
    logic [1:0]  seq_m [MAX_LEN];
    int          cur_round, tgt_m, to_m, pts_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] s);
        logic [3:0] one;
        one = 4'b0001;
        return one << s;
    endfunction

    task automatic model_gen();
        lfsr_m = lstep(lfsr_m);
        seq_m[cur_round-1] = lfsr_m[1:0];
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_leds"},  32'(leds),      0);
        check({tag, "_round"}, 32'(round),     0);
        check({tag, "_pts"},   32'(points),    0);
        check({tag, "_busy"},  32'(busy),      0);
        check({tag, "_turn"},  32'(user_turn), 0);
        check({tag, "_match"}, 32'(match),     0);
        check({tag, "_win"},   32'(win),       0);
        check({tag, "_lose"},  32'(lose),      0);
    endtask

    task automatic begin_game(input logic [15:0] s, input int t, input int to);
        seed = s; target_len = 5'(t); timeout_ticks = 4'(to);
        start = 1'b1;
        step();
        start = 1'b0;
        tgt_m     = (t == 0) ? 1 : ((t > MAX_LEN) ? MAX_LEN : t);
        to_m      = (to == 0) ? 1 : to;
        lfsr_m    = (s == 16'h0000) ? 16'hACE1 : s;
        cur_round = 1;
        pts_m     = 0;
        check("start_busy",  32'(busy),   1);
        check("start_round", 32'(round),  1);
        check("start_pts",   32'(points), 0);
        check("start_win",   32'(win),    0);
        check("start_lose",  32'(lose),   0);
        model_gen();
    endtask

    // Walks the playback of the current round; from_gen means the DUT is
    // still in its one-cycle generate state.
    task automatic play_round(input bit from_gen);
        if (from_gen) step();
        for (int i = 0; i < cur_round; i++) begin
            check("led_on", 32'(leds), 32'(oh(seq_m[i])));
            if (i == 0) begin
                step();
                check("led_hold", 32'(leds), 32'(oh(seq_m[i])));
            end
            check("play_busy", 32'(busy), 1);
            check("play_turn", 32'(user_turn), 0);
            tick = 1'b1; step(); tick = 1'b0;
            check("led_off", 32'(leds), 0);
            tick = 1'b1; step(); tick = 1'b0;
        end
        check("user_turn", 32'(user_turn), 1);
        check("wait_leds", 32'(leds), 0);
    endtask

    task automatic apply(input logic [3:0] b, input logic t, input logic em, input logic el);
        exp_t e;
        e.m = em;
        e.l = el;
        sb.push_back(e);
        btn = b; tick = t;
        step();
        btn = '0; tick = 1'b0;
        e = sb.pop_front();
        check("match", 32'(match), 32'(e.m));
        check("lose",  32'(lose),  32'(e.l));
    endtask

    task automatic finish_round();
        pts_m += cur_round;
        if (pts_m > 255) pts_m = 255;
        check("points", 32'(points), 32'(pts_m));
        if (cur_round == tgt_m) begin
            check("win",      32'(win),   1);
            check("win_busy", 32'(busy),  0);
            check("win_leds", 32'(leds),  0);
            check("win_round", 32'(round), 32'(cur_round));
        end else begin
            cur_round++;
            check("next_round", 32'(round), 32'(cur_round));
            check("gen_busy",   32'(busy),  1);
            model_gen();
        end
    endtask

    task automatic answer_round();
        for (int i = 0; i < cur_round; i++) begin
            apply(oh(seq_m[i]), 1'b0, 1'b1, 1'b0);
        end
        finish_round();
    endtask

    // kind 0: wrong single button, 1: two buttons, 2: timeout
    task automatic do_fail(input int kind);
        logic [1:0] wrong;
        logic       last;
        for (int a = 0; a < N_ATT; a++) begin
            last  = (a == N_ATT - 1);
            wrong = seq_m[0] + 2'd1;
            case (kind)
                0: apply(oh(wrong), 1'b0, 1'b0, last);
                1: apply(4'b0011, 1'b0, 1'b0, last);
                default: begin
                    for (int t = 0; t < to_m - 1; t++) apply(4'b0000, 1'b1, 1'b0, 1'b0);
                    apply(4'b0000, 1'b1, 1'b0, last);
                end
            endcase
            if (!last) begin
                check("retry_busy", 32'(busy), 1);
                check("retry_pts",  32'(points), 32'(pts_m));
                play_round(1'b0);
            end
        end
        check("lose_busy",  32'(busy),      0);
        check("lose_turn",  32'(user_turn), 0);
        check("lose_win",   32'(win),       0);
        check("lose_round", 32'(round),     32'(cur_round));
        check("lose_pts",   32'(points),    32'(pts_m));
        step();
        check("lose_hold",  32'(lose),      1);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; tick = 1'b0; btn = '0;
        target_len = '0; timeout_ticks = '0; seed = '0;
        step(); step();
        check_all_zero("rst");
        reset = 1'b1;
        step();
        check("idle_busy", 32'(busy), 0);

        // Three-round win from seed 1.
        begin_game(16'h0001, 3, 4);
        for (int r = 0; r < 3; r++) begin
            play_round(1'b1);
            answer_round();
        end
        step(); step();
        check("win_hold", 32'(win), 1);
        check("win_pts6", 32'(points), 6);

        // Longer game with a more varied sequence.
        begin_game(16'h1234, 4, 5);
        for (int r = 0; r < 4; r++) begin
            play_round(1'b1);
            answer_round();
        end

        // Wrong button in round 2.
        begin_game(16'h0001, 3, 4);
        play_round(1'b1);
        answer_round();
        play_round(1'b1);
        do_fail(0);

        // Two buttons at once.
        begin_game(16'hBEEF, 3, 4);
        play_round(1'b1);
        do_fail(1);

        // Press coinciding with the final tick wins; timer clears per press.
        begin_game(16'h1234, 2, 4);
        play_round(1'b1);
        repeat (3) apply(4'b0000, 1'b1, 1'b0, 1'b0);
        apply(oh(seq_m[0]), 1'b1, 1'b1, 1'b0);
        finish_round();
        play_round(1'b1);
        repeat (3) apply(4'b0000, 1'b1, 1'b0, 1'b0);
        apply(oh(seq_m[0]), 1'b0, 1'b1, 1'b0);
        repeat (3) apply(4'b0000, 1'b1, 1'b0, 1'b0);
        apply(oh(seq_m[1]), 1'b0, 1'b1, 1'b0);
        finish_round();

        // Plain timeout after 4 ticks.
        begin_game(16'h2468, 2, 4);
        play_round(1'b1);
        do_fail(2);

        // Start during playback is ignored.
        begin_game(16'h00FF, 2, 3);
        step();
        seed = 16'h5555; target_len = 5'd9; start = 1'b1;
        step();
        start = 1'b0;
        check("ign_round", 32'(round), 1);
        check("ign_busy",  32'(busy),  1);
        check("ign_leds",  32'(leds),  32'(oh(seq_m[0])));
        play_round(1'b0);
        answer_round();
        play_round(1'b1);
        answer_round();

        // Reset in the middle of playback.
        begin_game(16'hC0DE, 3, 4);
        play_round(1'b1);
        answer_round();
        step();
        check("pre_rst_leds", 32'(leds), 32'(oh(seq_m[0])));
        reset = 1'b0;
        step();
        check_all_zero("mid_rst");
        reset = 1'b1;
        step();

        // Clamps: target 0 -> 1 round, timeout 0 -> 1 tick, seed 0 -> default.
        begin_game(16'h0000, 0, 0);
        play_round(1'b1);
        do_fail(2);
        begin_game(16'h0000, 0, 5);
        play_round(1'b1);
        answer_round();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
